// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp codes,
// FSM states, opcode classes and datapath mux select codes.
package mips_pkg;

   localparam int ALUOP_WIDTH = 3;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = 3'b000;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = 3'b001;
   localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = 3'b010;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SLT   = 3'b011;
   localparam logic [ALUOP_WIDTH-1:0] ALU_AND   = 3'b100;
   localparam logic [ALUOP_WIDTH-1:0] ALU_OR    = 3'b101;
   localparam logic [ALUOP_WIDTH-1:0] ALU_XOR   = 3'b110;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEQ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10
   } state_t;

   typedef enum logic [2:0] {
      CLS_R       = 3'd0,
      CLS_I       = 3'd1,
      CLS_LW      = 3'd2,
      CLS_SW      = 3'd3,
      CLS_BEQ     = 3'd4,
      CLS_BNE     = 3'd5,
      CLS_J       = 3'd6,
      CLS_ILLEGAL = 3'd7
   } opclass_t;

   // States that stall on the memory handshake and are guarded by the watchdog.
   function automatic logic isMemWait(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Maps the instruction opcode to its execution class, the ALUOp used by
// I-type arithmetic, and a legality flag.
module opcode_class_decode
   import mips_pkg::*;
#(
   parameter bit JUMP_EN = 1'b1
) (
   input  logic [5:0]             i_opcode,
   output opclass_t               o_class,
   output logic [ALUOP_WIDTH-1:0] o_iAluOp,
   output logic                   o_legal
);

   always_comb begin
      o_class  = CLS_ILLEGAL;
      o_iAluOp = ALU_ADD;
      o_legal  = 1'b1;
      case (i_opcode)
         OP_RTYPE: o_class = CLS_R;
         OP_ADDI:  begin o_class = CLS_I; o_iAluOp = ALU_ADD; end
         OP_SLTI:  begin o_class = CLS_I; o_iAluOp = ALU_SLT; end
         OP_ANDI:  begin o_class = CLS_I; o_iAluOp = ALU_AND; end
         OP_ORI:   begin o_class = CLS_I; o_iAluOp = ALU_OR;  end
         OP_XORI:  begin o_class = CLS_I; o_iAluOp = ALU_XOR; end
         OP_LW:    o_class = CLS_LW;
         OP_SW:    o_class = CLS_SW;
         OP_BEQ:   o_class = CLS_BEQ;
         OP_BNE:   o_class = CLS_BNE;
         OP_J: begin
            if (JUMP_EN) o_class = CLS_J;
            else         o_legal = 1'b0;
         end
         default:  o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control: a Moore FSM sequencing fetch/decode/execute/
// memory/write-back, with a watchdog on every memory handshake wait.
module mc_control
   import mips_pkg::*;
#(
   parameter int ALUOP_W = 3,
   parameter int TIMEOUT = 16,
   parameter bit JUMP_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               ALUSrcA,
   output logic               RegWrite,
   output logic               RegDst,
   output logic [1:0]         BranchOp,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               illegal_op,
   output logic               mem_err,
   output logic [3:0]         state
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t                 r_state;
   opclass_t               r_class;
   logic [ALUOP_WIDTH-1:0] r_iAluOp;
   logic [CNT_W-1:0]       r_count;

   opclass_t               w_class;
   logic [ALUOP_WIDTH-1:0] w_iAluOp;
   logic                   w_legal;
   logic                   w_waitState;
   logic                   w_expire;
   logic                   w_leave;
   logic [ALUOP_WIDTH-1:0] w_aluOp;

   opcode_class_decode #(.JUMP_EN(JUMP_EN)) u_decode (
      .i_opcode (opcode),
      .o_class  (w_class),
      .o_iAluOp (w_iAluOp),
      .o_legal  (w_legal)
   );

   assign w_waitState = isMemWait(r_state);
   assign w_expire    = (TIMEOUT != 0) && w_waitState && !mem_ready &&
                        (r_count == CNT_W'(TIMEOUT - 1));
   // Every state change restarts the wait count, so each wait state starts from zero.
   assign w_leave     = !w_waitState || mem_ready || w_expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_FETCH;
         r_class  <= CLS_R;
         r_iAluOp <= ALU_ADD;
         r_count  <= '0;
      end else begin
         r_count <= w_leave ? '0 : r_count + CNT_W'(1);
         case (r_state)
            S_FETCH: if (mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               r_class  <= w_class;
               r_iAluOp <= w_iAluOp;
               case (w_class)
                  CLS_R:           r_state <= S_EXEC_R;
                  CLS_I:           r_state <= S_EXEC_I;
                  CLS_LW, CLS_SW:  r_state <= S_MEM_ADDR;
                  CLS_BEQ, CLS_BNE: r_state <= S_BRANCH;
                  CLS_J:           r_state <= S_JUMP;
                  default:         r_state <= S_FETCH;
               endcase
            end
            S_EXEC_R, S_EXEC_I: r_state <= S_ALU_WB;
            S_MEM_ADDR: r_state <= (r_class == CLS_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
               if (mem_ready)     r_state <= S_MEM_WB;
               else if (w_expire) r_state <= S_FETCH;
            end
            S_MEM_WRITE: if (mem_ready || w_expire) r_state <= S_FETCH;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   // IRWrite/PCWrite in FETCH are the only outputs qualified by mem_ready.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      BranchOp    = BR_NONE;
      ALUSrcB     = SRCB_RT;
      PCSource    = PCSRC_ALU;
      w_aluOp     = ALU_ADD;
      illegal_op  = 1'b0;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB    = SRCB_IMM_SH2;
            illegal_op = !w_legal;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            w_aluOp = ALU_FUNCT;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            w_aluOp = r_iAluOp;
         end
         S_ALU_WB: begin
            RegWrite = 1'b1;
            RegDst   = (r_class == CLS_R);
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEM_WRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            w_aluOp     = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            BranchOp    = (r_class == CLS_BNE) ? BR_BNE : BR_BEQ;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   assign ALUOp   = ALUOP_W'(w_aluOp);
   assign mem_err = w_expire;
   assign state   = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: two instances (default parameters, and
// TIMEOUT=4 with JUMP_EN=0) driven in lockstep against an instruction-level model.
`timescale 1ns/1ps
module tb_mc_control;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;

   logic [1:0] pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic [1:0] memtoReg, aluSrcA, regWrite, regDst, illegalOp, memErr;
   logic [1:0] branchOp[2];
   logic [1:0] aluSrcB[2];
   logic [1:0] pcSource[2];
   logic [2:0] aluOp[2];
   logic [3:0] stateOut[2];
   logic [24:0] act[2];

   mc_control #(.ALUOP_W(3), .TIMEOUT(16), .JUMP_EN(1'b1)) dutA (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(pcWrite[0]), .PCWriteCond(pcWriteCond[0]), .IorD(iorD[0]),
      .MemRead(memRead[0]), .MemWrite(memWrite[0]), .IRWrite(irWrite[0]),
      .MemtoReg(memtoReg[0]), .ALUSrcA(aluSrcA[0]), .RegWrite(regWrite[0]),
      .RegDst(regDst[0]), .BranchOp(branchOp[0]), .ALUSrcB(aluSrcB[0]),
      .PCSource(pcSource[0]), .ALUOp(aluOp[0]), .illegal_op(illegalOp[0]),
      .mem_err(memErr[0]), .state(stateOut[0])
   );

   mc_control #(.ALUOP_W(3), .TIMEOUT(4), .JUMP_EN(1'b0)) dutB (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(pcWrite[1]), .PCWriteCond(pcWriteCond[1]), .IorD(iorD[1]),
      .MemRead(memRead[1]), .MemWrite(memWrite[1]), .IRWrite(irWrite[1]),
      .MemtoReg(memtoReg[1]), .ALUSrcA(aluSrcA[1]), .RegWrite(regWrite[1]),
      .RegDst(regDst[1]), .BranchOp(branchOp[1]), .ALUSrcB(aluSrcB[1]),
      .PCSource(pcSource[1]), .ALUOp(aluOp[1]), .illegal_op(illegalOp[1]),
      .mem_err(memErr[1]), .state(stateOut[1])
   );

   assign act[0] = {pcWrite[0], pcWriteCond[0], iorD[0], memRead[0], memWrite[0],
                    irWrite[0], memtoReg[0], aluSrcA[0], regWrite[0], regDst[0],
                    branchOp[0], aluSrcB[0], pcSource[0], aluOp[0], illegalOp[0],
                    memErr[0], stateOut[0]};
   assign act[1] = {pcWrite[1], pcWriteCond[1], iorD[1], memRead[1], memWrite[1],
                    irWrite[1], memtoReg[1], aluSrcA[1], regWrite[1], regDst[1],
                    branchOp[1], aluSrcB[1], pcSource[1], aluOp[1], illegalOp[1],
                    memErr[1], stateOut[1]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: current step number, pending steps of the instruction, and wait count.
   int         mState[2];
   int         mWaits[2];
   logic [5:0] mOp[2];
   int         route[2][4];
   int         routeLen[2];
   int         routeIdx[2];
   int         tmo[2];
   bit         jen[2];
   int         nTests;
   int         nFail;

   typedef struct {
      logic [5:0] op;
      int         latA;
      int         latB;
      int         alu3;
   } vec_t;
   vec_t       vecs[13];
   logic [5:0] opList[11];

   function automatic bit isLegal(input logic [5:0] op, input bit jumpEn);
      case (op)
         6'b000000, 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110,
         6'b100011, 6'b101011, 6'b000100, 6'b000101: return 1'b1;
         6'b000010: return jumpEn;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] iTypeAlu(input logic [5:0] op);
      case (op)
         6'b001010: return 3'd3;
         6'b001100: return 3'd4;
         6'b001101: return 3'd5;
         6'b001110: return 3'd6;
         default:   return 3'd0;
      endcase
   endfunction

   function automatic bit isWait(input int s);
      return (s == 0) || (s == 3) || (s == 5);
   endfunction

   function automatic void resetModel(input int k);
      mState[k] = 0; mWaits[k] = 0; mOp[k] = 6'd0; routeLen[k] = 0; routeIdx[k] = 0;
   endfunction

   function automatic void pushStep(input int k, input int s);
      route[k][routeLen[k]] = s;
      routeLen[k]++;
   endfunction

   function automatic void loadRoute(input int k, input logic [5:0] op);
      routeLen[k] = 0; routeIdx[k] = 0;
      if (isLegal(op, jen[k])) begin
         case (op)
            6'b000000: begin pushStep(k, 6); pushStep(k, 8); end
            6'b100011: begin pushStep(k, 2); pushStep(k, 3); pushStep(k, 4); end
            6'b101011: begin pushStep(k, 2); pushStep(k, 5); end
            6'b000100, 6'b000101: pushStep(k, 9);
            6'b000010: pushStep(k, 10);
            default:   begin pushStep(k, 7); pushStep(k, 8); end
         endcase
      end
   endfunction

   function automatic int popStep(input int k);
      int s;
      s = 0;
      if (routeIdx[k] < routeLen[k]) begin
         s = route[k][routeIdx[k]];
         routeIdx[k]++;
      end
      return s;
   endfunction

   function automatic void advanceModel(input int k, input logic [5:0] op, input logic rdy);
      int s;
      s = mState[k];
      if (isWait(s) && !rdy) begin
         if (tmo[k] != 0 && mWaits[k] == tmo[k] - 1) begin
            mState[k] = 0; mWaits[k] = 0; routeLen[k] = 0; routeIdx[k] = 0;
         end else begin
            mWaits[k]++;
         end
      end else begin
         mWaits[k] = 0;
         if (s == 0) mState[k] = 1;
         else if (s == 1) begin
            mOp[k] = op;
            loadRoute(k, op);
            mState[k] = popStep(k);
         end else mState[k] = popStep(k);
      end
   endfunction

   function automatic logic [24:0] modelOut(input int k, input logic [5:0] liveOp, input logic rdy);
      logic pcw, pcwc, iord, memRd, memW, irw, m2r, srcA, regW, rDst, ill, expire;
      logic [1:0] br, srcB, pcSrc;
      logic [2:0] alu;
      logic [3:0] st;
      {pcw, pcwc, iord, memRd, memW, irw, m2r, srcA, regW, rDst, ill} = 11'd0;
      br = 2'd0; srcB = 2'd0; pcSrc = 2'd0; alu = 3'd0;
      st = 4'(mState[k]);
      expire = isWait(mState[k]) && !rdy && tmo[k] != 0 && mWaits[k] == tmo[k] - 1;
      case (mState[k])
         0:  begin memRd = 1; srcB = 2'd1; irw = rdy; pcw = rdy; end
         1:  begin srcB = 2'd3; ill = !isLegal(liveOp, jen[k]); end
         2:  begin srcA = 1; srcB = 2'd2; end
         3:  begin memRd = 1; iord = 1; end
         4:  begin regW = 1; m2r = 1; end
         5:  begin memW = 1; iord = 1; end
         6:  begin srcA = 1; alu = 3'd2; end
         7:  begin srcA = 1; srcB = 2'd2; alu = iTypeAlu(mOp[k]); end
         8:  begin regW = 1; rDst = (mOp[k] == 6'd0); end
         9:  begin srcA = 1; alu = 3'd1; pcwc = 1; pcSrc = 2'd1;
                   br = (mOp[k] == 6'b000100) ? 2'd1 : 2'd2; end
         10: begin pcw = 1; pcSrc = 2'd2; end
         default: ;
      endcase
      return {pcw, pcwc, iord, memRd, memW, irw, m2r, srcA, regW, rDst,
              br, srcB, pcSrc, alu, ill, expire, st};
   endfunction

   task automatic checkOutput(input int k, input logic [5:0] op, input logic rdy);
      logic [24:0] exp;
      exp = modelOut(k, op, rdy);
      nTests++;
      if (act[k] !== exp) begin
         nFail++;
         $display("[TB] FAIL ctrl%0d t=%0t step=%0d: got %b, expected %b",
                  k, $time, mState[k], act[k], exp);
      end
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      nTests++;
      if (actual != expected) begin
         nFail++;
         $display("[TB] FAIL %s t=%0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // One clock cycle: drive at the negedge, compare, then let the edge advance the model.
   task automatic applyStimulus(input logic [5:0] op, input logic rdy);
      opcode    = op;
      mem_ready = rdy;
      #1;
      checkOutput(0, op, rdy);
      checkOutput(1, op, rdy);
      @(posedge clk);
      if (rst_n) begin
         advanceModel(0, op, rdy);
         advanceModel(1, op, rdy);
      end
      @(negedge clk);
   endtask

   task automatic applyReset();
      mem_ready = 1'b0;
      rst_n     = 1'b0;
      #2;
      resetModel(0);
      resetModel(1);
      checkOutput(0, opcode, 1'b0);
      checkOutput(1, opcode, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global time limit reached");
      $fatal(1, "[TB] aborted");
   end

   initial begin
      int latA, latB, wCnt, eCnt, errCycle;
      logic [5:0] rop;
      logic rrdy;
      nTests = 0; nFail = 0;
      tmo[0] = 16; jen[0] = 1'b1;
      tmo[1] = 4;  jen[1] = 1'b0;
      resetModel(0); resetModel(1);
      rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b0;

      vecs[0]  = '{6'b000000, 4, 4, 2};
      vecs[1]  = '{6'b001000, 4, 4, 0};
      vecs[2]  = '{6'b001010, 4, 4, 3};
      vecs[3]  = '{6'b001100, 4, 4, 4};
      vecs[4]  = '{6'b001101, 4, 4, 5};
      vecs[5]  = '{6'b001110, 4, 4, 6};
      vecs[6]  = '{6'b100011, 5, 5, 0};
      vecs[7]  = '{6'b101011, 4, 4, 0};
      vecs[8]  = '{6'b000100, 3, 3, 1};
      vecs[9]  = '{6'b000101, 3, 3, 1};
      vecs[10] = '{6'b000010, 3, 2, 0};
      vecs[11] = '{6'b111111, 2, 2, 0};
      vecs[12] = '{6'b000011, 2, 2, 0};
      opList = '{6'b000000, 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110,
                 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010};

      @(negedge clk);

      // Per-opcode latency with mem_ready held high, plus ALUOp in cycle 3.
      for (int i = 0; i < 13; i++) begin
         applyReset();
         latA = 0; latB = 0;
         for (int c = 1; c <= 12 && (latA == 0 || latB == 0); c++) begin
            if (c == 3) checkValue($sformatf("alu3_op%b", vecs[i].op), int'(aluOp[0]), vecs[i].alu3);
            applyStimulus(vecs[i].op, 1'b1);
            if (latA == 0 && stateOut[0] == 4'd0) latA = c;
            if (latB == 0 && stateOut[1] == 4'd0) latB = c;
         end
         checkValue($sformatf("latA_op%b", vecs[i].op), latA, vecs[i].latA);
         checkValue($sformatf("latB_op%b", vecs[i].op), latB, vecs[i].latB);
      end

      // Reset asserted while lw is waiting in MEM_READ.
      applyReset();
      for (int c = 0; c < 3; c++) applyStimulus(6'b100011, 1'b1);
      for (int c = 0; c < 2; c++) applyStimulus(6'b100011, 1'b0);
      checkValue("midReadState", int'(stateOut[0]), 3);
      #2 rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      resetModel(0); resetModel(1);
      checkValue("rstState", int'(stateOut[0]), 0);
      checkValue("rstRegWrite", int'(regWrite[0]), 0);
      checkValue("rstMemRead", int'(memRead[0]), 1);
      checkValue("rstErr", int'(memErr[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(6'b000000, 1'b1);
      checkValue("fetchAfterReset", int'(stateOut[0]), 1);

      // lw with three wait cycles in MEM_READ; dutB completes exactly at its limit.
      applyReset();
      latA = 0;
      for (int c = 1; c <= 8; c++) begin
         if (c == 8) begin
            checkValue("lwMemtoReg", int'(memtoReg[0]), 1);
            checkValue("lwRegWrite", int'(regWrite[0]), 1);
         end
         applyStimulus(6'b100011, (c >= 4 && c <= 6) ? 1'b0 : 1'b1);
         if (latA == 0 && stateOut[0] == 4'd0) latA = c;
      end
      checkValue("lwWaitLatency", latA, 8);
      checkValue("lwWaitEndB", int'(stateOut[1]), 0);

      // sw with mem_ready stuck low: dutB's watchdog fires on the 4th MEM_WRITE cycle.
      applyReset();
      for (int c = 0; c < 3; c++) applyStimulus(6'b101011, 1'b1);
      mem_ready = 1'b0;
      #1;
      wCnt = 0; eCnt = 0; errCycle = 0;
      for (int c = 1; c <= 6; c++) begin
         if (memWrite[1]) wCnt++;
         if (memErr[1]) begin eCnt++; errCycle = c; end
         applyStimulus(6'b101011, 1'b0);
      end
      checkValue("swMemWriteCycles", wCnt, 4);
      checkValue("swErrPulses", eCnt, 1);
      checkValue("swErrCycle", errCycle, 4);
      checkValue("swAbortState", int'(stateOut[1]), 0);
      checkValue("swStillWaitingA", int'(stateOut[0]), 5);

      // Random opcodes and handshake timing against the model.
      applyReset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 7) == 0) rop = 6'($urandom_range(0, 63));
         else rop = opList[$urandom_range(0, 10)];
         rrdy = ($urandom_range(0, 9) < 7);
         applyStimulus(rop, rrdy);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the MIPS datapath. It replaces the single-cycle opcode decoder with a registered Moore FSM that sequences fetch, decode, execute, memory and write-back over several cycles. Memory accesses wait on a `mem_ready` handshake, guarded by a parametrised watchdog counter. It sits between the instruction register's opcode field and the multicycle datapath's muxes and write enables.

## Interface
- `ALUOP_W`, 3: ALUOp width. Encodings are 000 add, 001 sub, 010 funct-decoded, 011 slt, 100 and, 101 or, 110 xor.
- `TIMEOUT`, 16: maximum cycles to wait for `mem_ready`. A value of 0 disables the watchdog.
- `JUMP_EN`, 1: when 1, opcode 000010 (j) is legal. When 0, it is treated as illegal.
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `opcode` in 6: IR[31:26], sampled in DECODE.
- `mem_ready` in 1: memory has completed the current read or write.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst` out 1: datapath controls.
- `BranchOp` out 2: 00 none, 01 beq, 10 bne.
- `ALUSrcB` out 2: 00 rt, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `ALUOp` out `ALUOP_W`: ALU operation select.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `mem_err` out 1: one-cycle pulse on watchdog expiry.
- `state` out 4: current state, for debug.

## Operation
- States:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JUMP=10.
  - Encodings 11-15 are unreachable and recover to FETCH.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - IRWrite and PCWrite are asserted only in the cycle where `mem_ready`=1.
  - Moves to DECODE on `mem_ready`, otherwise holds.
- DECODE:
  - Asserts ALUSrcA=0, ALUSrcB=11, ALUOp=add, which precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 000000 → EXEC_R.
    - 001000/001010/001100/001101/001110 → EXEC_I.
    - 100011/101011 → MEM_ADDR.
    - 000100/000101 → BRANCH.
    - 000010 with `JUMP_EN` → JUMP.
    - Any other opcode → FETCH, with `illegal_op`=1 in this cycle.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=010, then ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ALUOp is add/slt/and/or/xor for addi/slti/andi/ori/xori. Then ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0. RegDst=1 for R-type, 0 otherwise. Then FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=add. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Moves to MEM_WB on `mem_ready`.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Moves to FETCH on `mem_ready`.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01.
  - BranchOp is 01 for beq, 10 for bne. Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- The decoded opcode class is registered in DECODE. Later states use the registered class, not the live `opcode`.
- Outputs not listed for a state are 0.
- Watchdog:
  - A `TIMEOUT`-sized counter clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - It increments each cycle that the FSM waits with `mem_ready`=0.
  - When the count reaches `TIMEOUT`-1 with `mem_ready` still 0: pulse `mem_err`, suppress IRWrite/PCWrite/RegWrite, and go to FETCH.
  - If `mem_ready` rises in the expiry cycle, the access completes normally and `mem_err`=0.

## Timing
- Reset: state=FETCH, registered class=R-type, counter=0. `illegal_op` and `mem_err` are 0.
  - In FETCH, outputs follow the FETCH decode, so MemRead=1 during reset.
  - Reset may assert in any state, including mid-memory-wait. It aborts without a write pulse.
- Latency with `mem_ready` held 1:
  - R-type and I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne, j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each memory wait cycle adds 1 cycle.
- Outputs are combinational from the registered state and class. The `mem_ready`-qualified enables are the only Mealy outputs.

## Structure
- `mips_pkg` holds:
  - opcode constants;
  - ALUOp encodings (`ALUOP_W`-sized);
  - the state enum or localparams;
  - the opcode class encoding;
  - the BranchOp and PCSource codes.
- One combinational sub-module, `opcode_class_decode`, maps opcode and `JUMP_EN` to {class, I-type ALUOp, legal}.
- The FSM, counter and output decode stay in `mc_control`.

## Test plan
- Reset mid-MEM_READ, then release with `mem_ready`=1 → state=FETCH, no RegWrite pulse, and an instruction is fetched in the first cycle.
- add (000000), `mem_ready`=1 → states 0,1,6,8,0. RegWrite=1 with RegDst=1 in cycle 4, and ALUOp=010 in cycle 3.
- lw (100011) with `mem_ready` low for 3 cycles in MEM_READ → 8 cycles total. MemtoReg=1 and RegWrite=1 in the final cycle.
- bne (000101) → BRANCH with PCWriteCond=1, BranchOp=10, ALUOp=001. Back in FETCH on cycle 4.
- Opcode 111111, or 000010 with `JUMP_EN`=0 → `illegal_op` pulses for 1 cycle in DECODE, then FETCH, with no write enables asserted.
- `TIMEOUT`=4, sw with `mem_ready` stuck 0 → `mem_err` pulses in the 4th MEM_WRITE cycle, then FETCH. MemWrite is asserted for exactly 4 cycles.
